// File: rtl/lb_fill_ctrl.sv
// Line-fill engine: on a line-buffer miss, issues one burst read, assembles
// NUM_BEATS beats into a line and delivers it as a single-cycle fill pulse.
module lb_fill_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int BEAT_WIDTH = 64,
  parameter int NUM_BEATS  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            miss_valid,
  input  logic [ADDR_WIDTH-1:0]           miss_addr,
  output logic                            miss_ready,
  input  logic                            flush,
  output logic [ADDR_WIDTH-1:0]           bmem_addr,
  output logic                            bmem_read,
  input  logic                            bmem_ready,
  input  logic                            bmem_rvalid,
  input  logic [BEAT_WIDTH-1:0]           bmem_rdata,
  output logic                            fill_valid,
  output logic [ADDR_WIDTH-1:0]           fill_addr,
  output logic [NUM_BEATS*BEAT_WIDTH-1:0] fill_data,
  output logic                            busy
);

  localparam int LINE_BYTES = NUM_BEATS * BEAT_WIDTH / 8;
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int CNT_W      = $clog2(NUM_BEATS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RECV = 2'd2,
    S_FILL = 2'd3
  } state_e;

  state_e                                 state_q, state_d;
  logic                                   squash_q, squash_d;
  logic [CNT_W-1:0]                       beat_cnt_q, beat_cnt_d;
  logic [ADDR_WIDTH-1:0]                  line_addr_q, line_addr_d;
  logic [NUM_BEATS-1:0][BEAT_WIDTH-1:0]   data_q, data_d;
  logic                                   last_beat_s;
  logic                                   unused_offset_s;

  assign last_beat_s     = (beat_cnt_q == CNT_W'(NUM_BEATS - 1));
  // Byte offset within the line never reaches memory; the line is fetched whole.
  assign unused_offset_s = ^miss_addr[OFF_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      squash_q    <= 1'b0;
      beat_cnt_q  <= '0;
      line_addr_q <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      squash_q    <= squash_d;
      beat_cnt_q  <= beat_cnt_d;
      line_addr_q <= line_addr_d;
      data_q      <= data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    squash_d    = squash_q;
    beat_cnt_d  = beat_cnt_q;
    line_addr_d = line_addr_q;
    data_d      = data_q;
    case (state_q)
      S_IDLE: begin
        if (miss_valid && !flush) begin
          line_addr_d = {miss_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
          squash_d    = 1'b0;
          state_d     = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (bmem_ready) begin
          // An accepted request cannot be cancelled; a same-cycle flush only squashes it.
          state_d    = S_RECV;
          beat_cnt_d = '0;
          squash_d   = flush;
        end else if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_REQ;
        end
      end
      S_RECV: begin
        squash_d = squash_q | flush;
        if (bmem_rvalid) begin
          data_d[beat_cnt_q] = bmem_rdata;
          beat_cnt_d         = beat_cnt_q + CNT_W'(1);
          if (last_beat_s) begin
            state_d = (!squash_q && !flush) ? S_FILL : S_IDLE;
          end else begin
            state_d = S_RECV;
          end
        end else begin
          state_d = S_RECV;
        end
      end
      S_FILL: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    miss_ready = 1'b0;
    bmem_read  = 1'b0;
    fill_valid = 1'b0;
    busy       = 1'b1;
    case (state_q)
      S_IDLE: begin
        miss_ready = 1'b1;
        busy       = 1'b0;
      end
      S_REQ: begin
        bmem_read = 1'b1;
      end
      S_RECV: begin
        bmem_read = 1'b0;
      end
      S_FILL: begin
        fill_valid = !flush;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign bmem_addr = line_addr_q;
  assign fill_addr = line_addr_q;
  assign fill_data = data_q;

endmodule

// File: tb/tb_lb_fill_ctrl.sv
// Self-checking bench for lb_fill_ctrl: table of fill transactions plus
// hand-written flush/reset sequences; fills are checked against a scoreboard.
module tb_lb_fill_ctrl;

  logic         clk;
  logic         rst;
  logic         miss_valid;
  logic [31:0]  miss_addr;
  logic         miss_ready;
  logic         flush;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_ready;
  logic         bmem_rvalid;
  logic [63:0]  bmem_rdata;
  logic         fill_valid;
  logic [31:0]  fill_addr;
  logic [255:0] fill_data;
  logic         busy;

  lb_fill_ctrl #(.ADDR_WIDTH(32), .BEAT_WIDTH(64), .NUM_BEATS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .miss_valid  (miss_valid),
    .miss_addr   (miss_addr),
    .miss_ready  (miss_ready),
    .flush       (flush),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_ready  (bmem_ready),
    .bmem_rvalid (bmem_rvalid),
    .bmem_rdata  (bmem_rdata),
    .fill_valid  (fill_valid),
    .fill_addr   (fill_addr),
    .fill_data   (fill_data),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flush_beat: -1 none, 0..3 flush together with that beat, 4 flush during the fill cycle
  typedef struct {
    logic [31:0] addr;
    int          ready_delay;
    int          gap;
    logic [63:0] base;
    int          flush_beat;
    logic [31:0] exp_addr;
    bit          exp_fill;
  } vec_t;

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] data;
  } fill_t;

  fill_t sb_q[$];
  vec_t  v[8];
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon();
    fill_t f;
    if (fill_valid !== 1'b0) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fill: got fill_valid=%b addr %h expected no fill", fill_valid, fill_addr);
      end else begin
        f = sb_q.pop_front();
        chk("fill_addr", fill_addr, f.addr);
        chk("fill_data", fill_data, f.data);
      end
    end
  endtask

  // Inputs are set at a negedge; outputs are observed 1ns later, then the clock advances.
  task automatic cyc();
    #1;
    mon();
    @(negedge clk);
  endtask

  task automatic beat(input logic [63:0] d);
    bmem_rvalid = 1'b1;
    bmem_rdata  = d;
    cyc();
    bmem_rvalid = 1'b0;
  endtask

  task automatic do_fill(input vec_t t);
    logic [255:0] line;
    bit           goes_fill;
    miss_valid = 1'b1;
    miss_addr  = t.addr;
    cyc();
    miss_valid = 1'b0;
    chk("req_read", bmem_read, 1'b1);
    chk("req_addr", bmem_addr, t.exp_addr);
    chk("req_busy", busy, 1'b1);
    chk("req_miss_ready", miss_ready, 1'b0);
    for (int d = 0; d < t.ready_delay; d++) begin
      miss_valid = 1'b1;
      miss_addr  = 32'hFFFF_FFE0;
      cyc();
      miss_valid = 1'b0;
      chk("stall_read", bmem_read, 1'b1);
      chk("stall_addr", bmem_addr, t.exp_addr);
      chk("stall_busy", busy, 1'b1);
    end
    bmem_ready = 1'b1;
    cyc();
    bmem_ready = 1'b0;
    chk("recv_read", bmem_read, 1'b0);
    for (int i = 0; i < 4; i++) line[64*i +: 64] = t.base + 64'(i);
    goes_fill = !(t.flush_beat >= 0 && t.flush_beat <= 3);
    if (t.exp_fill) sb_q.push_back('{addr: t.exp_addr, data: line});
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < t.gap; g++) begin
        cyc();
        chk("gap_busy", busy, 1'b1);
      end
      flush = (t.flush_beat == i);
      beat(t.base + 64'(i));
      flush = 1'b0;
    end
    chk("post_burst_busy", busy, goes_fill);
    if (goes_fill) begin
      flush = (t.flush_beat == 4);
      cyc();
      flush = 1'b0;
    end
    chk("idle_busy", busy, 1'b0);
    chk("idle_miss_ready", miss_ready, 1'b1);
    chk("hold_fill_addr", fill_addr, t.exp_addr);
    chk("hold_fill_data", fill_data, line);
  endtask

  initial begin
    v[0] = '{32'h0000_0014, 0, 0, 64'h1111_0000_0000_0000, -1, 32'h0000_0000, 1'b1};
    v[1] = '{32'h1234_5678, 5, 2, 64'hAAAA_5555_0000_0000, -1, 32'h1234_5660, 1'b1};
    v[2] = '{32'h0000_0100, 0, 0, 64'h2222_0000_0000_0010,  2, 32'h0000_0100, 1'b0};
    v[3] = '{32'h0000_0200, 1, 1, 64'h3333_0000_0000_0020, -1, 32'h0000_0200, 1'b1};
    v[4] = '{32'h0000_0040, 0, 0, 64'h4444_0000_0000_0030, -1, 32'h0000_0040, 1'b1};
    v[5] = '{32'h0000_0060, 0, 0, 64'h5555_0000_0000_0040, -1, 32'h0000_0060, 1'b1};
    v[6] = '{32'h0000_007C, 0, 0, 64'h6666_0000_0000_0050,  4, 32'h0000_0060, 1'b0};
    v[7] = '{32'h0000_003F, 0, 0, 64'h7777_0000_0000_0060,  3, 32'h0000_0020, 1'b0};

    rst         = 1'b1;
    miss_valid  = 1'b0;
    miss_addr   = 32'h0;
    flush       = 1'b0;
    bmem_ready  = 1'b0;
    bmem_rvalid = 1'b1;
    bmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    cyc();
    cyc();
    bmem_rvalid = 1'b0;
    rst         = 1'b0;
    chk("rst_miss_ready", miss_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bmem_read", bmem_read, 1'b0);
    chk("rst_fill_valid", fill_valid, 1'b0);
    chk("rst_fill_addr", fill_addr, 32'h0);
    chk("rst_fill_data", fill_data, 256'h0);

    // Stale beats in IDLE must be ignored
    beat(64'hFFFF_0000_FFFF_0000);
    chk("idle_rvalid_data", fill_data, 256'h0);
    chk("idle_rvalid_busy", busy, 1'b0);

    for (int k = 0; k < 8; k++) do_fill(v[k]);

    // Miss together with flush in IDLE is dropped
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_0500;
    flush      = 1'b1;
    cyc();
    miss_valid = 1'b0;
    flush      = 1'b0;
    chk("drop_busy", busy, 1'b0);
    chk("drop_read", bmem_read, 1'b0);

    // Flush in REQ before accept withdraws the request
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_0300;
    cyc();
    miss_valid = 1'b0;
    chk("wd_read_before", bmem_read, 1'b1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("wd_read_after", bmem_read, 1'b0);
    chk("wd_busy", busy, 1'b0);
    chk("wd_miss_ready", miss_ready, 1'b1);

    // Flush on the accept cycle squashes the whole burst
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_0320;
    cyc();
    miss_valid = 1'b0;
    bmem_ready = 1'b1;
    flush      = 1'b1;
    cyc();
    bmem_ready = 1'b0;
    flush      = 1'b0;
    chk("sq_busy", busy, 1'b1);
    for (int i = 0; i < 4; i++) beat(64'hC0DE_0000_0000_0000 + 64'(i));
    chk("sq_done_busy", busy, 1'b0);

    // Reset in the middle of a burst
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_0400;
    cyc();
    miss_valid = 1'b0;
    bmem_ready = 1'b1;
    cyc();
    bmem_ready = 1'b0;
    beat(64'h9999_0000_0000_0000);
    beat(64'h9999_0000_0000_0001);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_miss_ready", miss_ready, 1'b1);
    chk("mrst_read", bmem_read, 1'b0);
    chk("mrst_fill_addr", fill_addr, 32'h0);
    chk("mrst_fill_data", fill_data, 256'h0);
    beat(64'h9999_0000_0000_0002);
    beat(64'h9999_0000_0000_0003);
    chk("stray_fill_data", fill_data, 256'h0);
    chk("stray_busy", busy, 1'b0);

    do_fill(v[0]);
    cyc();
    chk("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
